// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg: register map, bit indices, reset constants and
// write-strobe decode shared by the multi-channel interval timer.
package multi_timer_pkg;

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CTRL    = 3'd1;
  localparam logic [2:0] REG_PER_LO  = 3'd2;
  localparam logic [2:0] REG_PER_HI  = 3'd3;
  localparam logic [2:0] REG_SNAP_LO = 3'd4;
  localparam logic [2:0] REG_SNAP_HI = 3'd5;
  localparam logic [2:0] REG_CMP_LO  = 3'd6;
  localparam logic [2:0] REG_CMP_HI  = 3'd7;

  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;

  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  localparam int DEF_RESET_PERIOD = 49999;

  typedef struct packed {
    logic status;
    logic ctrl;
    logic per_lo;
    logic per_hi;
    logic snap;
    logic cmp_lo;
    logic cmp_hi;
  } ch_wr_t;

  function automatic ch_wr_t wr_decode(
    input logic       en,
    input logic [2:0] r
  );
    ch_wr_t w;
    w = '0;
    if (en) begin
      unique case (r)
        REG_STATUS:  w.status = 1'b1;
        REG_CTRL:    w.ctrl   = 1'b1;
        REG_PER_LO:  w.per_lo = 1'b1;
        REG_PER_HI:  w.per_hi = 1'b1;
        REG_SNAP_LO: w.snap   = 1'b1;
        REG_SNAP_HI: w.snap   = 1'b1;
        REG_CMP_LO:  w.cmp_lo = 1'b1;
        REG_CMP_HI:  w.cmp_hi = 1'b1;
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// multi_timer_channel: one down-counter with period, snapshot, TO/RUN and irq.
// Compare register and pwm output exist only with MULTI_TIMER_PWM_EN.
module multi_timer_channel
  import multi_timer_pkg::*;
#(
  parameter int COUNT_W      = 32,
  parameter int RESET_PERIOD = DEF_RESET_PERIOD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  ch_wr_t      wr,
  input  logic [15:0] wdata,
  input  logic [2:0]  rsel,
  output logic [15:0] rdata,
  output logic        irq,
  output logic        pwm
);

  logic [COUNT_W-1:0] count;
  logic [COUNT_W-1:0] period;
  logic [COUNT_W-1:0] per_new;
  logic [COUNT_W-1:0] snap;
  logic [3:0]         ctrl;
  logic               run;
  logic               to;
  logic               timeout;
  logic               reload;
  logic [31:0]        per32;
  logic [31:0]        snap32;
  logic [31:0]        cmp32;

  assign timeout = tick && run && (count == '0);
  assign reload  = wr.per_lo || wr.per_hi;

  always_comb begin
    per_new = period;
    if (wr.per_lo) per_new[15:0] = wdata;
    if (wr.per_hi) per_new[COUNT_W-1:16] = wdata[COUNT_W-17:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= COUNT_W'(RESET_PERIOD);
      period <= COUNT_W'(RESET_PERIOD);
      snap   <= '0;
      ctrl   <= '0;
      run    <= 1'b0;
      to     <= 1'b0;
    end else begin
      period <= per_new;
      if (reload)
        count <= per_new;
      else if (timeout)
        count <= period;
      else if (tick && run)
        count <= count - COUNT_W'(1);
      if (wr.snap) snap <= count;
      if (wr.ctrl) ctrl <= wdata[3:0];
      // START beats both STOP and a forced reload
      if (wr.ctrl && wdata[CTL_START])
        run <= 1'b1;
      else if (reload || (wr.ctrl && wdata[CTL_STOP]))
        run <= 1'b0;
      else if (timeout)
        run <= ctrl[CTL_CONT];
      if (timeout)
        to <= 1'b1;
      else if (wr.status)
        to <= 1'b0;
    end
  end

`ifdef MULTI_TIMER_PWM_EN
  logic [COUNT_W-1:0] cmp;
  logic               pwm_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cmp   <= '0;
      pwm_q <= 1'b0;
    end else begin
      if (wr.cmp_lo) cmp[15:0] <= wdata;
      if (wr.cmp_hi) cmp[COUNT_W-1:16] <= wdata[COUNT_W-17:0];
      pwm_q <= run && (count < cmp);
    end
  end

  assign cmp32 = 32'(cmp);
  assign pwm   = pwm_q;
`else
  logic unused_cmp;
  assign unused_cmp = wr.cmp_lo | wr.cmp_hi;
  assign cmp32      = '0;
  assign pwm        = 1'b0;
`endif

  assign per32  = 32'(period);
  assign snap32 = 32'(snap);
  assign irq    = to && ctrl[CTL_ITO];

  always_comb begin
    rdata = '0;
    unique case (rsel)
      REG_STATUS:  rdata = {14'd0, run, to};
      REG_CTRL:    rdata = {12'd0, ctrl};
      REG_PER_LO:  rdata = per32[15:0];
      REG_PER_HI:  rdata = per32[31:16];
      REG_SNAP_LO: rdata = snap32[15:0];
      REG_SNAP_HI: rdata = snap32[31:16];
      REG_CMP_LO:  rdata = cmp32[15:0];
      REG_CMP_HI:  rdata = cmp32[31:16];
    endcase
  end

endmodule

// File: rtl/multi_interval_timer.sv
// multi_interval_timer: N-channel Avalon-MM interval timer with shared prescaler.
// Optional per-channel pwm compare enabled by MULTI_TIMER_PWM_EN.
module multi_interval_timer
  import multi_timer_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int COUNT_W      = 32,
  parameter int RESET_PERIOD = DEF_RESET_PERIOD,
  parameter int PRESCALE     = 1,
  parameter int ADDR_W       = $clog2(NUM_CH) + 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [15:0]       writedata,
  output logic [15:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_vec,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]   ps;
  logic              tick;
  logic [ADDR_W-1:0] ch_idx;
  logic [2:0]        reg_sel;
  logic              wr_en;
  logic [15:0]       rd [NUM_CH];
  logic [15:0]       rd_sel;

  assign tick = (ps == PS_W'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (reset)
      ps <= '0;
    else if (tick)
      ps <= '0;
    else
      ps <= ps + PS_W'(1);
  end

  assign ch_idx  = address >> 3;
  assign reg_sel = address[2:0];
  assign wr_en   = chipselect && !write_n;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    multi_timer_channel #(
      .COUNT_W      (COUNT_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .wr    (wr_decode(wr_en && (ch_idx == ADDR_W'(i)), reg_sel)),
      .wdata (writedata),
      .rsel  (reg_sel),
      .rdata (rd[i]),
      .irq   (irq_vec[i]),
      .pwm   (pwm_out[i])
    );
  end

  // unpopulated channel slots fall through to zero
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (ch_idx == ADDR_W'(i)) rd_sel = rd[i];
  end

  always_ff @(posedge clk) begin
    if (reset)
      readdata <= '0;
    else
      readdata <= rd_sel;
  end

  assign irq = |irq_vec;

endmodule

// File: tb/tb_multi_interval_timer.sv
// tb_multi_interval_timer: directed scenarios plus random bus traffic
// checked against a closed-form timing model of each channel.
module tb_multi_interval_timer;

  localparam int NUM_CH       = 3;
  localparam int COUNT_W      = 24;
  localparam int RESET_PERIOD = 49999;
  localparam int PRESCALE     = 1;
  localparam int ADDR_W       = $clog2(NUM_CH) + 3;
  localparam longint CMASK    = (64'd1 << COUNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [15:0]       writedata;
  logic [15:0]       readdata;
  logic              irq;
  logic [NUM_CH-1:0] irq_vec;
  logic [NUM_CH-1:0] pwm_out;

  always #5 clk = ~clk;

  multi_interval_timer #(
    .NUM_CH       (NUM_CH),
    .COUNT_W      (COUNT_W),
    .RESET_PERIOD (RESET_PERIOD),
    .PRESCALE     (PRESCALE),
    .ADDR_W       (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_vec    (irq_vec),
    .pwm_out    (pwm_out)
  );

  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;
  bit     mdl_on  = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // model: state after edge m_a is (m_c0, m_run0, m_to0); later edges follow
  // from elapsed-edge arithmetic (one tick per edge with PRESCALE=1)
  longint   m_a    [NUM_CH];
  longint   m_c0   [NUM_CH];
  longint   m_per  [NUM_CH];
  longint   m_snap [NUM_CH];
  bit       m_run0 [NUM_CH];
  bit       m_to0  [NUM_CH];
  bit [3:0] m_ctrl [NUM_CH];

  typedef struct {
    longint cnt;
    bit     run;
    bit     to;
    bit     hit;
  } st_t;

  function automatic longint n_to(longint k, longint c0, longint p, bit cont);
    if (k <= c0) return 0;
    return cont ? (k - c0 - 1) / (p + 1) + 1 : 1;
  endfunction

  function automatic st_t eval(int ch, longint n);
    st_t    s;
    longint k, c0, p;
    bit     cont;
    k    = n - m_a[ch];
    c0   = m_c0[ch];
    p    = m_per[ch];
    cont = m_ctrl[ch][1];
    s.cnt = c0;
    s.run = m_run0[ch];
    s.to  = m_to0[ch];
    s.hit = 0;
    if (m_run0[ch]) begin
      if (k <= c0) s.cnt = c0 - k;
      else s.cnt = cont ? p - (k - c0 - 1) % (p + 1) : p;
      s.run = cont || (k <= c0);
      s.to  = m_to0[ch] || (n_to(k, c0, p, cont) > 0);
      s.hit = (k > 0) && (n_to(k, c0, p, cont) > n_to(k - 1, c0, p, cont));
    end
    return s;
  endfunction

  task automatic model_reset(longint n);
    for (int i = 0; i < NUM_CH; i++) begin
      m_a[i]    = n;
      m_c0[i]   = RESET_PERIOD;
      m_per[i]  = RESET_PERIOD;
      m_snap[i] = 0;
      m_run0[i] = 0;
      m_to0[i]  = 0;
      m_ctrl[i] = 0;
    end
  endtask

  task automatic model_write(int ch, int r, logic [15:0] d, longint e);
    st_t s, sp;
    s  = eval(ch, e);
    sp = eval(ch, e - 1);
    case (r)
      0: if (!s.hit) s.to = 0;
      1: begin
        m_ctrl[ch] = d[3:0];
        if (d[2]) s.run = 1;
        else if (d[3]) s.run = 0;
      end
      2: begin
        m_per[ch] = (m_per[ch] & ~64'hFFFF) | longint'(d);
        s.cnt = m_per[ch];
        s.run = 0;
      end
      3: begin
        m_per[ch] = ((m_per[ch] & 64'hFFFF) | (longint'(d) << 16)) & CMASK;
        s.cnt = m_per[ch];
        s.run = 0;
      end
      4, 5: m_snap[ch] = sp.cnt;
      default: ;
    endcase
    m_a[ch]    = e;
    m_c0[ch]   = s.cnt;
    m_run0[ch] = s.run;
    m_to0[ch]  = s.to;
  endtask

  function automatic longint exp_rd(int ch, int r, longint n);
    st_t s;
    if (ch >= NUM_CH) return 0;
    s = eval(ch, n);
    case (r)
      0: return (longint'(s.run) << 1) | longint'(s.to);
      1: return longint'(m_ctrl[ch]);
      2: return m_per[ch] & 64'hFFFF;
      3: return m_per[ch] >> 16;
      4: return m_snap[ch] & 64'hFFFF;
      5: return m_snap[ch] >> 16;
      default: return 0;
    endcase
  endfunction

  bit          pend = 0;
  int          p_ch, p_r;
  logic [15:0] p_d;

  task automatic step();
    logic [NUM_CH-1:0] ev;
    st_t s;
    @(posedge clk);
    cyc++;
    #1;
    if (pend) begin
      model_write(p_ch, p_r, p_d, cyc);
      pend = 0;
    end
    if (mdl_on) begin
      ev = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        s = eval(i, cyc);
        ev[i] = s.to && m_ctrl[i][0];
      end
      check("irq_vec", irq_vec, ev);
      check("irq", irq, |ev);
    end
  endtask

  task automatic wr(int ch, int r, logic [15:0] d);
    address    = ADDR_W'(ch * 8 + r);
    chipselect = 1;
    write_n    = 0;
    writedata  = d;
    pend       = mdl_on && (ch < NUM_CH);
    p_ch       = ch;
    p_r        = r;
    p_d        = d;
    step();
    chipselect = 0;
    write_n    = 1;
  endtask

  task automatic rd(int ch, int r, output logic [15:0] q);
    address    = ADDR_W'(ch * 8 + r);
    chipselect = 1;
    write_n    = 1;
    step();
    q          = readdata;
    chipselect = 0;
  endtask

  task automatic wait_irq(int ch, int max, output int n);
    n = 0;
    while (!irq_vec[ch] && n < max) begin
      step();
      n++;
    end
  endtask

  initial begin : main
    logic [15:0] q;
    int          n, hi_cnt, op, ch, r;
    reset = 1; address = '0; chipselect = 0; write_n = 1; writedata = '0;
    step();
    step();
    check("rst_readdata", readdata, 0);
    check("rst_irq", irq, 0);
    check("rst_irq_vec", irq_vec, 0);
    check("rst_pwm", pwm_out, 0);
    reset = 0;
    rd(0, 2, q); check("rst_per_lo", q, 49999);
    rd(0, 3, q); check("rst_per_hi", q, 0);
    rd(0, 0, q); check("rst_status", q, 0);
    rd(3, 2, q); check("bad_ch_read", q, 0);

    // ch1 continuous, period 9
    wr(1, 2, 9);
    wr(1, 1, 7);
    wait_irq(1, 50, n); check("ch1_first_to", n, 10);
    wr(1, 0, 0);
    check("ch1_to_clear", irq_vec[1], 0);
    wait_irq(1, 50, n); check("ch1_second_to", n, 9);
    repeat (9) step();
    wr(1, 0, 0);
    check("ch1_to_setwins", irq_vec[1], 1);
    rd(1, 0, q); check("ch1_status", q, 3);
    wr(1, 1, 16'h8);
    wr(1, 0, 0);

    // ch2 one-shot, period 4
    wr(2, 2, 4);
    wr(2, 1, 5);
    wait_irq(2, 50, n); check("ch2_oneshot", n, 5);
    rd(2, 0, q); check("ch2_status", q, 1);
    wr(2, 4, 0);
    rd(2, 4, q); check("ch2_reload", q, 4);
    wr(2, 0, 0);
    repeat (20) step();
    check("ch2_no_retrig", irq_vec[2], 0);

    // ch0 snapshot, forced reload, START+STOP
    wr(0, 2, 100);
    wr(0, 1, 4);
    repeat (20) step();
    wr(0, 4, 0);
    rd(0, 4, q); check("ch0_snap_lo", q, 80);
    rd(0, 5, q); check("ch0_snap_hi", q, 0);
    rd(0, 0, q); check("ch0_running", q, 2);
    wr(0, 2, 50);
    rd(0, 0, q); check("ch0_reload_stop", q, 0);
    wr(0, 4, 0);
    rd(0, 4, q); check("ch0_reload_cnt", q, 50);
    wr(0, 1, 16'hC);
    rd(0, 0, q); check("ch0_start_stop", q, 2);
    rd(0, 1, q); check("ch0_ctrl", q, 16'hC);
    wr(0, 3, 16'hFFFF);
    rd(0, 3, q); check("ch0_per_hi_mask", q, 16'h00FF);
    rd(0, 2, q); check("ch0_per_lo_keep", q, 50);

`ifdef MULTI_TIMER_PWM_EN
    wr(1, 7, 0);
    wr(1, 6, 3);
    rd(1, 6, q); check("ch1_cmp_lo", q, 3);
    wr(1, 2, 9);
    wr(1, 1, 7);
    repeat (3) step();
    hi_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (pwm_out[1]) hi_cnt++;
    end
    check("pwm_duty", hi_cnt, 3);
`else
    wr(0, 6, 16'h1234);
    wr(0, 7, 16'h0055);
    rd(0, 6, q); check("cmp_lo_absent", q, 0);
    rd(0, 7, q); check("cmp_hi_absent", q, 0);
    wr(1, 2, 9);
    wr(1, 1, 7);
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (pwm_out != 0) hi_cnt++;
    end
    check("pwm_tied_low", hi_cnt, 0);
`endif

    // reset while channels run, then random traffic against the model
    reset = 1;
    step();
    reset = 0;
    model_reset(cyc);
    check("midrst_irq_vec", irq_vec, 0);
    mdl_on = 1;
    rd(1, 0, q); check("midrst_status", q, 0);
    rd(1, 2, q); check("midrst_per", q, 49999);

    repeat (400) begin
      op = $urandom_range(0, 9);
      ch = $urandom_range(0, NUM_CH - 1);
      case (op)
        0, 1, 2: begin
          ch = $urandom_range(0, NUM_CH);
          r  = $urandom_range(0, 5);
          rd(ch, r, q);
          check($sformatf("rnd_rd_c%0d_r%0d", ch, r), q, exp_rd(ch, r, cyc - 1));
        end
        3: wr(ch, 2, 16'($urandom_range(0, 30)));
        4: wr(ch, 3, ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'd0);
        5, 6: wr(ch, 1, 16'($urandom_range(0, 15)));
        7: wr(ch, 0, 16'($urandom));
        8: wr(ch, 4 + $urandom_range(0, 1), 16'($urandom));
        default: begin
          n = $urandom_range(1, 25);
          repeat (n) step();
        end
      endcase
    end

    for (int c = 0; c < NUM_CH; c++)
      for (int k = 0; k < 6; k++) begin
        rd(c, k, q);
        check($sformatf("final_c%0d_r%0d", c, k), q, exp_rd(c, k, cyc - 1));
      end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
